go_sync_multi: RTL and testbench

//  N-channel successor of the toggle-based go synchroniser. Receives toggle-encoded go events

---
 rtl/go_sync_pkg.sv | 16 +
 rtl/go_sync_chan.sv | 52 +++++
 rtl/go_sync_multi.sv | 60 ++++++
 tb/tb_go_sync_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/go_sync_pkg.sv
// go_sync_pkg: shared helpers and default sizing for the go_sync_multi synchroniser.
// Overflow mode is selected by defining GO_SYNC_OVF_STICKY_EN.
package go_sync_pkg;
  localparam int N_CH_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ch_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/go_sync_chan.sv
// go_sync_chan: one toggle channel - synchroniser, arm window, edge detect, saturating event counter.
// GO_SYNC_OVF_STICKY_EN makes ovf_o sticky until ovf_clr_i; otherwise ovf_o is a one-cycle pulse.
module go_sync_chan
  import go_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic tog_i,
  input  logic grant_i,
  input  logic ovf_clr_i,
  output logic pend_o,
  output logic ovf_o
);
  localparam int AW = clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_N = AW'(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [AW-1:0] arm_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic edge_q, ovf_q, ovf_d, armed, ev, drop;
  assign armed  = arm_q == ARM_N;
  assign ev     = armed & (sync_q[SYNC_STAGES-1] ^ edge_q);
  assign drop   = ev & ~grant_i & (&cnt_q);
  assign cnt_d  = drop ? cnt_q : cnt_q + CNT_W'(ev) - CNT_W'(grant_i);
  assign pend_o = |cnt_q;
  assign ovf_o  = ovf_q;
`ifdef GO_SYNC_OVF_STICKY_EN
  assign ovf_d = drop | (ovf_q & ~ovf_clr_i);
`else
  logic unused_clr;
  assign unused_clr = ovf_clr_i;
  assign ovf_d = drop;
`endif
  // edge_q follows the sync output even while unarmed, so a resting-high source is absorbed
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      arm_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
      edge_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= armed ? arm_q : arm_q + 1'b1;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule

// File: rtl/go_sync_multi.sv
// go_sync_multi: N-channel toggle go synchroniser with per-channel queues and a round-robin valid/ready output.
// Overflow behaviour follows GO_SYNC_OVF_STICKY_EN (see go_sync_chan).
module go_sync_multi
  import go_sync_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  localparam int CH_W       = ch_w(N_CH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] tog_i,
  input  logic            go_rdy_i,
  output logic            go_vld_o,
  output logic [CH_W-1:0] go_ch_o,
  output logic            busy_o,
  input  logic            ovf_clr_i,
  output logic [N_CH-1:0] ovf_o
);
  logic [N_CH-1:0] pend, grant;
  logic [CH_W-1:0] rr_q, ch_q, win;
  logic vld_q, found, load;
  int idx;
  assign load = ~vld_q | go_rdy_i;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign grant[c] = load & found & (win == CH_W'(c));
    go_sync_chan #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) u_chan (
      .clk(clk), .rstn(rstn), .tog_i(tog_i[c]), .grant_i(grant[c]),
      .ovf_clr_i(ovf_clr_i), .pend_o(pend[c]), .ovf_o(ovf_o[c])
    );
  end
  // scan downward so the channel closest after rr_q is assigned last and wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = (int'(rr_q) + i) % N_CH;
      if (pend[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      ch_q  <= '0;
      rr_q  <= '0;
    end else if (load) begin
      vld_q <= found;
      ch_q  <= found ? win : ch_q;
      rr_q  <= found ? win : rr_q;
    end
  end
  assign go_vld_o = vld_q;
  assign go_ch_o  = (N_CH == 1) ? '0 : ch_q;
  assign busy_o   = vld_q | (|pend);
endmodule

// File: tb/tb_go_sync_multi.sv
// tb_go_sync_multi: scoreboard bench for go_sync_multi (default N_CH=4, SYNC_STAGES=2, CNT_W=3).
module tb_go_sync_multi;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] tog_i = 4'b0000;
  logic go_rdy_i = 1'b0;
  logic ovf_clr_i = 1'b0;
  logic go_vld_o, busy_o;
  logic [1:0] go_ch_o;
  logic [3:0] ovf_o;
  int n_chk = 0;
  int n_fail = 0;
  int n_del = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_ch;

  go_sync_multi dut (
    .clk(clk), .rstn(rstn), .tog_i(tog_i), .go_rdy_i(go_rdy_i), .go_vld_o(go_vld_o),
    .go_ch_o(go_ch_o), .busy_o(busy_o), .ovf_clr_i(ovf_clr_i), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && go_vld_o && go_rdy_i) begin
      n_chk++;
      n_del++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got ch=%0d, required no event", go_ch_o);
      end else begin
        exp_ch = exp_q.pop_front();
        if (go_ch_o !== exp_ch) begin
          n_fail++;
          $display("FAIL event_order: got ch=%0d, required ch=%0d", go_ch_o, exp_ch);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d events left, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    tog_i = 4'b1010;
    rstn = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({go_vld_o, go_ch_o, busy_o, ovf_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%b ch=%0d busy=%b ovf=%b, required all 0",
               go_vld_o, go_ch_o, busy_o, ovf_o);
    end
    rstn = 1'b1;
    go_rdy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (go_vld_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL arm_window cyc%0d: got vld=%b busy=%b, required 0 0", i, go_vld_o, busy_o);
      end
    end
  endtask

  task automatic test_round_robin();
    tog_i = ~tog_i;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    drain(20);
    tick();
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_busy_after: got %b, required 0", busy_o);
    end
  endtask

  task automatic test_single();
    tick();
    tog_i[2] = ~tog_i[2];
    exp_q.push_back(2'd2);
    for (int k = 1; k <= S + 4; k++) begin
      tick();
      n_chk++;
      if (go_vld_o !== (k == S + 2)) begin
        n_fail++;
        $display("FAIL single_timing k=%0d: got vld=%b, required %b", k, go_vld_o, k == S + 2);
      end
      if (k == S + 2) begin
        n_chk++;
        if (go_ch_o !== 2'd2) begin
          n_fail++;
          $display("FAIL single_ch: got %0d, required 2", go_ch_o);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int d0;
    go_rdy_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tog_i[1] = ~tog_i[1];
      exp_q.push_back(2'd1);
      tick();
      tick();
    end
    tog_i[1] = ~tog_i[1];
    tick();
    tick();
    n_chk++;
    if (ovf_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_early: got %b, required 0000", ovf_o);
    end
    tick();
    n_chk++;
    if (ovf_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_set: got %b, required 0010", ovf_o);
    end
    tick();
`ifdef GO_SYNC_OVF_STICKY_EN
    n_chk++;
    if (ovf_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_sticky_hold: got %b, required 0010", ovf_o);
    end
    tog_i[1] = ~tog_i[1];
    tick();
    tick();
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    n_chk++;
    if (ovf_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b, required 0010", ovf_o);
    end
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    n_chk++;
    if (ovf_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, required 0000", ovf_o);
    end
`else
    n_chk++;
    if (ovf_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_pulse_end: got %b, required 0000", ovf_o);
    end
`endif
    n_chk++;
    if (go_vld_o !== 1'b1 || go_ch_o !== 2'd1) begin
      n_fail++;
      $display("FAIL ovf_hold: got vld=%b ch=%0d, required 1 1", go_vld_o, go_ch_o);
    end
    d0 = n_del;
    go_rdy_i = 1'b1;
    drain(30);
    repeat (3) tick();
    n_chk++;
    if (n_del - d0 !== 8) begin
      n_fail++;
      $display("FAIL ovf_delivered: got %0d, required 8", n_del - d0);
    end
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_busy_after: got %b, required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    go_rdy_i = 1'b0;
    tog_i[2:0] = ~tog_i[2:0];
    repeat (6) tick();
    n_chk++;
    if (go_vld_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pending: got vld=%b busy=%b, required 1 1", go_vld_o, busy_o);
    end
    rstn = 1'b0;
    exp_q.delete();
    tick();
    rstn = 1'b1;
    n_chk++;
    if ({go_vld_o, go_ch_o, busy_o, ovf_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_state: got vld=%b ch=%0d busy=%b ovf=%b, required all 0",
               go_vld_o, go_ch_o, busy_o, ovf_o);
    end
    d0 = n_del;
    go_rdy_i = 1'b1;
    repeat (12) tick();
    n_chk++;
    if (n_del !== d0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_discard: got %0d events busy=%b, required 0 events busy=0", n_del - d0, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
